// File: rtl/serial_negator_16_bit.sv
// Bit-serial 16-bit negator: ones' complement (~x) or two's complement (-x),
// one bit per clock, LSB first, with a single registered result update.
module serial_negator_16_bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] x,
  output logic [15:0] y,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] sr;
  logic [3:0]  cnt;
  logic        carry;
  logic        ovf_pending;
  logic        b;
  logic        res_bit;
  logic        last_bit;

  // Two's complement is ~x plus a carry-in of 1; ones' complement is carry-in 0.
  assign b        = ~sr[0];
  assign res_bit  = b ^ carry;
  assign last_bit = (cnt == 4'd15);

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      carry       <= 1'b0;
      ovf_pending <= 1'b0;
      y           <= '0;
      overflow    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            sr          <= x;
            cnt         <= '0;
            carry       <= mode;
            // Flag is taken from the operand as captured, not the live input.
            ovf_pending <= mode && (x == 16'h8000);
          end
        end
        SHIFT: begin
          sr    <= {res_bit, sr[15:1]};
          carry <= b & carry;
          cnt   <= cnt + 4'd1;
          if (last_bit) begin
            y        <= {res_bit, sr[15:1]};
            overflow <= ovf_pending;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
